// File: rtl/nebula_pkg.sv
// ---------------------------------------------------------------------------
// nebula_pkg
// Shared types for the Nebula memory-side arbiter.
//   mem_src_t    : requester identity; the encoding is also the bus source ID
//                  (0 = imem, 1 = dmem, 2 = ptw) and the bit index used in
//                  request/grant/mask vectors.
//   arb_state_t  : arbiter FSM states.
//   SRC_COUNT    : number of requesters.
//   onehot_to_src: converts a one-hot grant vector into a mem_src_t.
// ---------------------------------------------------------------------------
package nebula_pkg;

   localparam int SRC_COUNT = 3;

   typedef enum logic [1:0] {
      SRC_IMEM = 2'd0,
      SRC_DMEM = 2'd1,
      SRC_PTW  = 2'd2
   } mem_src_t;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_WAIT  = 2'd2,
      ARB_RESP  = 2'd3
   } arb_state_t;

   function automatic mem_src_t onehot_to_src(input logic [SRC_COUNT-1:0] oh);
      mem_src_t s;
      if (oh[2])      s = SRC_PTW;
      else if (oh[1]) s = SRC_DMEM;
      else if (oh[0]) s = SRC_IMEM;
      else            s = SRC_IMEM;
      return s;
   endfunction

endpackage

// File: rtl/nebula_arb_select.sv
// ---------------------------------------------------------------------------
// nebula_arb_select
// Combinational grant selection: request vector, one-cycle mask and (in the
// round-robin build) the last granted source in, one-hot grant out.
// Build option: NEBULA_MEM_ARB_RR_EN
//   defined   : round-robin, search starts at the source after last_grant
//               in the order imem -> dmem -> ptw -> imem.
//   undefined : fixed priority ptw > dmem > imem; no last_grant input.
// Ports:
//   req        in  [SRC_COUNT-1:0] request levels, bit index = mem_src_t
//   mask       in  [SRC_COUNT-1:0] sources excluded this cycle
//   last_grant in  mem_src_t       (round-robin build only)
//   grant      out [SRC_COUNT-1:0] one-hot grant, all zero when nothing eligible
// ---------------------------------------------------------------------------
module nebula_arb_select
   import nebula_pkg::*;
(
   input  logic [SRC_COUNT-1:0] req,
   input  logic [SRC_COUNT-1:0] mask,
`ifdef NEBULA_MEM_ARB_RR_EN
   input  mem_src_t             last_grant,
`endif
   output logic [SRC_COUNT-1:0] grant
);

   logic [SRC_COUNT-1:0] eligible;

   assign eligible = req & ~mask;

`ifdef NEBULA_MEM_ARB_RR_EN
   logic [1:0] idx;
   logic       found;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = 2'd0;
      // Walk the ring starting one past the previous winner; the previous
      // winner itself is considered last.
      for (int k = 1; k <= SRC_COUNT; k++) begin
         idx = 2'((int'(last_grant) + k) % SRC_COUNT);
         if (!found && eligible[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end
`else
   always_comb begin
      grant = '0;
      if (eligible[SRC_PTW])       grant[SRC_PTW]  = 1'b1;
      else if (eligible[SRC_DMEM]) grant[SRC_DMEM] = 1'b1;
      else if (eligible[SRC_IMEM]) grant[SRC_IMEM] = 1'b1;
   end
`endif

endmodule

// File: rtl/nebula_mem_arbiter.sv
// ---------------------------------------------------------------------------
// nebula_mem_arbiter
// Serialises the core's I-cache, D-cache and PTW line requests onto a single
// downstream bus port, one transaction outstanding at a time, and steers the
// response back to the granted requester.
// Build option: NEBULA_MEM_ARB_RR_EN selects round-robin grant (see
// nebula_arb_select); otherwise fixed priority ptw > dmem > imem.
//
// Handshakes:
//   Requester side: *_req is a level held until the matching one-cycle *_ack;
//   data and error outputs are meaningful only while ack is high.
//   Bus request: a transfer happens on the cycle bus_req_valid && bus_req_ready;
//   once valid rises, all bus_req_* fields stay stable until that transfer.
//   Bus response: bus_resp_valid is a one-cycle pulse, honoured only while a
//   request has been accepted and is waiting for its response.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   imem_req/addr -> imem_ack/data/error        I-side line read
//   dmem_req/we/addr/wdata/is_amo/amo_op -> dmem_ack/rdata/error
//   ptw_mem_req/addr -> ptw_mem_ack/data/error  PTW word read
//   bus_req_valid/ready/we/addr/wdata/is_amo/amo_op/src   downstream request
//   bus_resp_valid/data/error                              downstream response
// ---------------------------------------------------------------------------
module nebula_mem_arbiter
   import nebula_pkg::*;
#(
   parameter int PADDR_WIDTH = 56,
   parameter int XLEN        = 64,
   parameter int LINE_BYTES  = 64
)
(
   input  logic                    clk,
   input  logic                    rst,

   input  logic                    imem_req,
   input  logic [PADDR_WIDTH-1:0]  imem_addr,
   output logic                    imem_ack,
   output logic [LINE_BYTES*8-1:0] imem_data,
   output logic                    imem_error,

   input  logic                    dmem_req,
   input  logic                    dmem_we,
   input  logic [PADDR_WIDTH-1:0]  dmem_addr,
   input  logic [LINE_BYTES*8-1:0] dmem_wdata,
   input  logic                    dmem_is_amo,
   input  logic [4:0]              dmem_amo_op,
   output logic                    dmem_ack,
   output logic [LINE_BYTES*8-1:0] dmem_rdata,
   output logic                    dmem_error,

   input  logic                    ptw_mem_req,
   input  logic [PADDR_WIDTH-1:0]  ptw_mem_addr,
   output logic                    ptw_mem_ack,
   output logic [XLEN-1:0]         ptw_mem_data,
   output logic                    ptw_mem_error,

   output logic                    bus_req_valid,
   input  logic                    bus_req_ready,
   output logic                    bus_req_we,
   output logic [PADDR_WIDTH-1:0]  bus_req_addr,
   output logic [LINE_BYTES*8-1:0] bus_req_wdata,
   output logic                    bus_req_is_amo,
   output logic [4:0]              bus_req_amo_op,
   output logic [1:0]              bus_req_src,
   input  logic                    bus_resp_valid,
   input  logic [LINE_BYTES*8-1:0] bus_resp_data,
   input  logic                    bus_resp_error
);

   localparam int LINE_W     = LINE_BYTES * 8;
   localparam int WORDS      = LINE_W / XLEN;
   localparam int WORD_SHIFT = $clog2(XLEN / 8);
   localparam logic [PADDR_WIDTH-1:0] LINE_MASK = PADDR_WIDTH'(LINE_BYTES - 1);
   localparam logic [PADDR_WIDTH-1:0] WORD_MASK = PADDR_WIDTH'(WORDS - 1);

   // FSM state and latched transaction
   arb_state_t              state;
   mem_src_t                src_q;
   logic                    we_q;
   logic                    amo_q;
   logic [4:0]              amo_op_q;
   logic [PADDR_WIDTH-1:0]  addr_q;
   logic [LINE_W-1:0]       wdata_q;
   logic                    err_q;
   logic [SRC_COUNT-1:0]    mask_q;

   // Per-channel response holding registers
   logic [LINE_W-1:0]       imem_data_q;
   logic [LINE_W-1:0]       dmem_data_q;
   logic [XLEN-1:0]         ptw_data_q;

   // Grant path
   logic [SRC_COUNT-1:0]    req_vec;
   logic [SRC_COUNT-1:0]    grant;
   mem_src_t                gsrc;
   logic [PADDR_WIDTH-1:0]  sel_addr;
   logic                    sel_we;
   logic                    sel_amo;
   logic [4:0]              sel_op;
   logic [LINE_W-1:0]       sel_wdata;

   // PTW word extraction
   logic [PADDR_WIDTH-1:0]  word_idx;
   logic [XLEN-1:0]         ptw_word;

   logic                    resp_cycle;

   assign req_vec = {ptw_mem_req, dmem_req, imem_req};

`ifdef NEBULA_MEM_ARB_RR_EN
   mem_src_t last_grant_q;

   nebula_arb_select u_select (
      .req        (req_vec),
      .mask       (mask_q),
      .last_grant (last_grant_q),
      .grant      (grant)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_q <= SRC_IMEM;
      end else if (state == ARB_IDLE && |grant) begin
         last_grant_q <= gsrc;
      end
   end
`else
   nebula_arb_select u_select (
      .req   (req_vec),
      .mask  (mask_q),
      .grant (grant)
   );
`endif

   assign gsrc = onehot_to_src(grant);

   // Only the D-side carries write/AMO attributes; the other sources are
   // plain line reads and present zeros in those fields.
   always_comb begin
      sel_addr  = imem_addr;
      sel_we    = 1'b0;
      sel_amo   = 1'b0;
      sel_op    = '0;
      sel_wdata = '0;
      case (gsrc)
         SRC_DMEM: begin
            sel_addr  = dmem_addr;
            sel_we    = dmem_we;
            sel_amo   = dmem_is_amo;
            sel_op    = dmem_amo_op;
            sel_wdata = dmem_wdata;
         end
         SRC_PTW:  sel_addr = ptw_mem_addr;
         default:  sel_addr = imem_addr;
      endcase
   end

   // Word within the line addressed by the PTE byte address.
   assign word_idx = (addr_q >> WORD_SHIFT) & WORD_MASK;

   always_comb begin
      ptw_word = '0;
      for (int i = 0; i < WORDS; i++) begin
         if (word_idx == PADDR_WIDTH'(i)) begin
            ptw_word = bus_resp_data[i*XLEN +: XLEN];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ARB_IDLE;
         src_q       <= SRC_IMEM;
         we_q        <= 1'b0;
         amo_q       <= 1'b0;
         amo_op_q    <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         err_q       <= 1'b0;
         mask_q      <= '0;
         imem_data_q <= '0;
         dmem_data_q <= '0;
         ptw_data_q  <= '0;
      end else begin
         case (state)
            ARB_IDLE: begin
               // The mask only ever covers this single IDLE cycle.
               mask_q <= '0;
               if (|grant) begin
                  src_q    <= gsrc;
                  addr_q   <= sel_addr;
                  we_q     <= sel_we;
                  amo_q    <= sel_amo;
                  amo_op_q <= sel_op;
                  wdata_q  <= sel_wdata;
                  state    <= ARB_ISSUE;
               end
            end
            ARB_ISSUE: begin
               if (bus_req_ready) state <= ARB_WAIT;
            end
            ARB_WAIT: begin
               if (bus_resp_valid) begin
                  err_q <= bus_resp_error;
                  case (src_q)
                     SRC_DMEM: dmem_data_q <= bus_resp_data;
                     SRC_PTW:  ptw_data_q  <= ptw_word;
                     default:  imem_data_q <= bus_resp_data;
                  endcase
                  state <= ARB_RESP;
               end
            end
            ARB_RESP: begin
               // Keep a requester that has not yet dropped its level from
               // being granted again straight away.
               mask_q <= SRC_COUNT'(1) << src_q;
               state  <= ARB_IDLE;
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

   assign resp_cycle = (state == ARB_RESP);

   assign bus_req_valid  = (state == ARB_ISSUE);
   assign bus_req_we     = we_q;
   assign bus_req_addr   = addr_q & ~LINE_MASK;
   assign bus_req_wdata  = wdata_q;
   assign bus_req_is_amo = amo_q;
   assign bus_req_amo_op = amo_op_q;
   assign bus_req_src    = src_q;

   assign imem_ack      = resp_cycle && (src_q == SRC_IMEM);
   assign dmem_ack      = resp_cycle && (src_q == SRC_DMEM);
   assign ptw_mem_ack   = resp_cycle && (src_q == SRC_PTW);
   assign imem_error    = imem_ack & err_q;
   assign dmem_error    = dmem_ack & err_q;
   assign ptw_mem_error = ptw_mem_ack & err_q;
   assign imem_data     = imem_data_q;
   assign dmem_rdata    = dmem_data_q;
   assign ptw_mem_data  = ptw_data_q;

endmodule

// File: tb/tb_nebula_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_nebula_mem_arbiter
// Self-checking bench for nebula_mem_arbiter. A bus responder process models
// the downstream port (configurable ready stall and response delay); the main
// process drives requesters and consumes acks against a scoreboard.
// Build option NEBULA_MEM_ARB_RR_EN adds a round-robin ordering scenario.
// ---------------------------------------------------------------------------
module tb_nebula_mem_arbiter;

   localparam int PW = 56;
   localparam int XL = 64;
   localparam int LB = 64;
   localparam int LW = LB * 8;
   localparam int EW = 2 + 1 + LW;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic          imem_req, imem_ack, imem_error;
   logic [PW-1:0] imem_addr;
   logic [LW-1:0] imem_data;
   logic          dmem_req, dmem_we, dmem_is_amo, dmem_ack, dmem_error;
   logic [PW-1:0] dmem_addr;
   logic [LW-1:0] dmem_wdata, dmem_rdata;
   logic [4:0]    dmem_amo_op;
   logic          ptw_mem_req, ptw_mem_ack, ptw_mem_error;
   logic [PW-1:0] ptw_mem_addr;
   logic [XL-1:0] ptw_mem_data;
   logic          bus_req_valid, bus_req_ready, bus_req_we, bus_req_is_amo;
   logic [PW-1:0] bus_req_addr;
   logic [LW-1:0] bus_req_wdata;
   logic [4:0]    bus_req_amo_op;
   logic [1:0]    bus_req_src;
   logic          bus_resp_valid, bus_resp_error;
   logic [LW-1:0] bus_resp_data;

   nebula_mem_arbiter #(.PADDR_WIDTH(PW), .XLEN(XL), .LINE_BYTES(LB)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_data(imem_data), .imem_error(imem_error),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_is_amo(dmem_is_amo), .dmem_amo_op(dmem_amo_op),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .dmem_error(dmem_error),
      .ptw_mem_req(ptw_mem_req), .ptw_mem_addr(ptw_mem_addr), .ptw_mem_ack(ptw_mem_ack),
      .ptw_mem_data(ptw_mem_data), .ptw_mem_error(ptw_mem_error),
      .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_we(bus_req_we),
      .bus_req_addr(bus_req_addr), .bus_req_wdata(bus_req_wdata),
      .bus_req_is_amo(bus_req_is_amo), .bus_req_amo_op(bus_req_amo_op),
      .bus_req_src(bus_req_src), .bus_resp_valid(bus_resp_valid),
      .bus_resp_data(bus_resp_data), .bus_resp_error(bus_resp_error)
   );

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [1:0]    src;
      logic          we;
      logic          amo;
      logic [4:0]    op;
      logic [PW-1:0] addr;
      logic [LW-1:0] wdata;
   } breq_t;

   logic [EW-1:0] exp_q[$];    // {src, error, data} expected on the ack
   breq_t         breq_q[$];   // expected bus request fields, grant order
   logic [LW-1:0] rline_q[$];  // line the responder returns
   logic          rerr_q[$];   // error the responder returns

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ---------------- bus responder ----------------
   int ready_delay = 0;
   int resp_delay  = 0;
   int last_stall  = 0;
   int stray_req   = 0;
   int stray_done  = 0;

   task automatic cmp_fields(input breq_t b);
      check("bus_src",    LW'(bus_req_src),    LW'(b.src));
      check("bus_we",     LW'(bus_req_we),     LW'(b.we));
      check("bus_amo",    LW'(bus_req_is_amo), LW'(b.amo));
      check("bus_amo_op", LW'(bus_req_amo_op), LW'(b.op));
      check("bus_addr",   LW'(bus_req_addr),   LW'(b.addr));
      check("bus_wdata",  bus_req_wdata,       b.wdata);
   endtask

   initial begin
      int phase = 0;
      int stall = 0;
      int wcnt  = 0;
      bus_req_ready  = 1'b0;
      bus_resp_valid = 1'b0;
      bus_resp_data  = '0;
      bus_resp_error = 1'b0;
      forever begin
         @(negedge clk);
         bus_resp_valid = 1'b0;
         if (rst) begin
            phase = 0;
            stall = 0;
            bus_req_ready = 1'b0;
         end else begin
            if (stray_req != stray_done) begin
               stray_done     = stray_req;
               bus_resp_valid = 1'b1;
               bus_resp_data  = {16{$urandom}};
               bus_resp_error = 1'b1;
            end
            if (phase == 0) begin
               if (bus_req_valid) begin
                  if (breq_q.size() == 0) begin
                     check("bus_req_unexpected", LW'(1), LW'(0));
                     bus_req_ready = 1'b1;
                     phase = 1;
                     wcnt  = 0;
                  end else begin
                     cmp_fields(breq_q[0]);
                     if (stall >= ready_delay) begin
                        bus_req_ready = 1'b1;
                        void'(breq_q.pop_front());
                        last_stall = stall;
                        stall = 0;
                        phase = 1;
                        wcnt  = 0;
                     end else begin
                        bus_req_ready = 1'b0;
                        stall++;
                     end
                  end
               end else begin
                  bus_req_ready = 1'b0;
               end
            end else begin
               bus_req_ready = 1'b0;
               if (wcnt >= resp_delay) begin
                  bus_resp_valid = 1'b1;
                  bus_resp_data  = (rline_q.size() != 0) ? rline_q.pop_front() : '0;
                  bus_resp_error = (rerr_q.size() != 0) ? rerr_q.pop_front() : 1'b0;
                  phase = 0;
               end else begin
                  wcnt++;
               end
            end
         end
      end
   end

   // ---------------- requester side ----------------
   int cyc = 0;
   int req_cyc = 0;
   int last_ack_cyc = 0;
   int hold_extra = 0;
   int drop_cnt[3] = '{0, 0, 0};

   task automatic set_req(input int s, input logic v);
      case (s)
         0: imem_req = v;
         1: dmem_req = v;
         default: ptw_mem_req = v;
      endcase
   endtask

   task automatic take_ack(input int s, input logic [LW-1:0] data, input logic err);
      logic [EW-1:0] e;
      last_ack_cyc = cyc;
      if (exp_q.size() == 0) begin
         check("ack_unexpected", LW'(1), LW'(0));
      end else begin
         e = exp_q.pop_front();
         check("ack_src",   LW'(s),   LW'(e[EW-1 -: 2]));
         check("ack_error", LW'(err), LW'(e[LW]));
         check("ack_data",  data,     e[LW-1:0]);
      end
      if (hold_extra == 0) set_req(s, 1'b0);
      else drop_cnt[s] = hold_extra;
   endtask

   task automatic tick();
      logic [2:0] acks;
      @(negedge clk);
      cyc++;
      for (int s = 0; s < 3; s++) begin
         if (drop_cnt[s] > 0) begin
            drop_cnt[s]--;
            if (drop_cnt[s] == 0) set_req(s, 1'b0);
         end
      end
      acks = {ptw_mem_ack, dmem_ack, imem_ack};
      if ($countones(acks) > 1) check("ack_onehot", LW'(acks), LW'(0));
      if (imem_ack)    take_ack(0, imem_data, imem_error);
      if (dmem_ack)    take_ack(1, dmem_rdata, dmem_error);
      if (ptw_mem_ack) take_ack(2, LW'(ptw_mem_data), ptw_mem_error);
   endtask

   function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] l;
      for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
      return l;
   endfunction

   // Push expectations for one transaction and raise its request.
   task automatic issue(input int s, input logic [PW-1:0] addr, input logic we,
                        input logic amo, input logic [4:0] op, input logic [LW-1:0] wdata,
                        input logic [LW-1:0] line, input logic err);
      breq_t         b;
      logic [LW-1:0] d;
      logic [2:0]    widx;
      b.src   = 2'(s);
      b.we    = (s == 1) ? we : 1'b0;
      b.amo   = (s == 1) ? amo : 1'b0;
      b.op    = (s == 1) ? op : 5'd0;
      b.wdata = (s == 1) ? wdata : '0;
      b.addr  = addr & ~PW'(LB - 1);
      breq_q.push_back(b);
      rline_q.push_back(line);
      rerr_q.push_back(err);
      widx = addr[5:3];
      d = (s == 2) ? LW'(line[int'(widx)*XL +: XL]) : line;
      exp_q.push_back({2'(s), err, d});
      req_cyc = cyc;
      case (s)
         0: begin imem_addr = addr; imem_req = 1'b1; end
         1: begin
            dmem_addr = addr; dmem_we = we; dmem_is_amo = amo;
            dmem_amo_op = op; dmem_wdata = wdata; dmem_req = 1'b1;
         end
         default: begin ptw_mem_addr = addr; ptw_mem_req = 1'b1; end
      endcase
   endtask

   task automatic wait_done(input int max);
      int n = 0;
      while ((exp_q.size() != 0 || imem_req || dmem_req || ptw_mem_req) && n < max) begin
         tick();
         n++;
      end
      if (n >= max) check("timeout", LW'(1), LW'(0));
   endtask

   task automatic check_outputs_zero(input string pfx);
      check({pfx, "_bus_valid"}, LW'(bus_req_valid), LW'(0));
      check({pfx, "_bus_addr"},  LW'(bus_req_addr),  LW'(0));
      check({pfx, "_bus_we"},    LW'(bus_req_we),    LW'(0));
      check({pfx, "_bus_src"},   LW'(bus_req_src),   LW'(0));
      check({pfx, "_acks"},      LW'({imem_ack, dmem_ack, ptw_mem_ack}), LW'(0));
      check({pfx, "_errs"},      LW'({imem_error, dmem_error, ptw_mem_error}), LW'(0));
      check({pfx, "_imem_data"}, imem_data,  LW'(0));
      check({pfx, "_dmem_data"}, dmem_rdata, LW'(0));
      check({pfx, "_ptw_data"},  LW'(ptw_mem_data), LW'(0));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [LW-1:0] wline;
      rst = 1'b1;
      imem_req = 1'b0; imem_addr = '0;
      dmem_req = 1'b0; dmem_we = 1'b0; dmem_addr = '0; dmem_wdata = '0;
      dmem_is_amo = 1'b0; dmem_amo_op = '0;
      ptw_mem_req = 1'b0; ptw_mem_addr = '0;
      tick(); tick();
      check_outputs_zero("reset");
      rst = 1'b0;
      tick();

      // Lone imem read; idle D-side attribute inputs must not leak onto the bus.
      dmem_we = 1'b1; dmem_is_amo = 1'b1; dmem_amo_op = 5'h1f; dmem_wdata = rand_line();
      issue(0, 56'h0000_8000_0047, 1'b0, 1'b0, 5'd0, '0, rand_line(), 1'b0);
      wait_done(50);
      // Request raised in cycle 0, ack in cycle 3: four cycles inclusive.
      check("imem_latency", LW'(last_ack_cyc - req_cyc), LW'(3));

      // Simultaneous ptw + imem: ptw first, imem afterwards; PTE at word 3.
      issue(2, 56'h1018, 1'b0, 1'b0, 5'd0, '0, rand_line(), 1'b0);
      issue(0, 56'h2000, 1'b0, 1'b0, 5'd0, '0, rand_line(), 1'b0);
      wait_done(50);

      // dmem writeback with ready held low 5 cycles; inputs change after grant.
      ready_delay = 5;
      wline = rand_line();
      issue(1, 56'h0000_00AB_CDC0, 1'b1, 1'b0, 5'd0, wline, rand_line(), 1'b0);
      tick(); tick();
      dmem_addr = 56'h0000_0000_1234; dmem_wdata = ~wline; dmem_we = 1'b0;
      wait_done(60);
      check("dmem_stall_cycles", LW'(last_stall), LW'(5));
      ready_delay = 0;

      // dmem AMO with a response delay.
      resp_delay = 2;
      issue(1, 56'h0000_0000_4008, 1'b0, 1'b1, 5'h0c, rand_line(), rand_line(), 1'b0);
      wait_done(50);
      resp_delay = 0;

      // Bus error on a PTW read.
      issue(2, 56'h0000_0000_3038, 1'b0, 1'b0, 5'd0, '0, rand_line(), 1'b1);
      wait_done(50);

      // Requester holds its level through the IDLE cycle after its ack.
      hold_extra = 2;
      issue(0, 56'h0000_0000_5000, 1'b0, 1'b0, 5'd0, '0, rand_line(), 1'b0);
      wait_done(50);
      check("no_regrant_valid", LW'(bus_req_valid), LW'(0));
      tick(); tick();
      check("no_regrant_valid2", LW'(bus_req_valid), LW'(0));
      hold_extra = 0;

      // Reset while waiting for a response, then a stray response.
      resp_delay = 50;
      issue(1, 56'h0000_0000_6040, 1'b0, 1'b0, 5'd0, rand_line(), rand_line(), 1'b0);
      tick(); tick(); tick(); tick();
      rst = 1'b1;
      dmem_req = 1'b0;
      tick(); tick();
      rst = 1'b0;
      exp_q.delete(); rline_q.delete(); rerr_q.delete();
      resp_delay = 0;
      tick();
      check_outputs_zero("post_reset");
      stray_req++;
      tick(); tick(); tick();
      check("stray_no_ack", LW'({imem_ack, dmem_ack, ptw_mem_ack}), LW'(0));
      check("stray_bus_idle", LW'(bus_req_valid), LW'(0));
      issue(0, 56'h0000_0000_7080, 1'b0, 1'b0, 5'd0, '0, rand_line(), 1'b0);
      wait_done(50);

`ifdef NEBULA_MEM_ARB_RR_EN
      // After a ptw grant the ring restarts at imem.
      issue(2, 56'h0000_0000_8000, 1'b0, 1'b0, 5'd0, '0, rand_line(), 1'b0);
      wait_done(50);
      for (int r = 0; r < 2; r++) begin
         issue(0, 56'h0000_0000_9000, 1'b0, 1'b0, 5'd0, '0, rand_line(), 1'b0);
         issue(1, 56'h0000_0000_9040, 1'b0, 1'b0, 5'd0, rand_line(), rand_line(), 1'b0);
         issue(2, 56'h0000_0000_9088, 1'b0, 1'b0, 5'd0, '0, rand_line(), 1'b0);
         wait_done(100);
      end
`endif

      // Random single transactions with random bus timing.
      for (int t = 0; t < 10; t++) begin
         int s;
         s = $urandom_range(0, 2);
         ready_delay = $urandom_range(0, 3);
         resp_delay  = $urandom_range(0, 3);
         issue(s, PW'({$urandom, $urandom}), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), rand_line(),
               rand_line(), 1'($urandom_range(0, 1)));
         wait_done(60);
      end

      tick(); tick();
      check("exp_q_empty",  LW'(exp_q.size()),  LW'(0));
      check("breq_q_empty", LW'(breq_q.size()), LW'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
